// File: rtl/if_pp_if.sv
// IF-stage bus bundle: instruction-memory request/response plus the IF->ID instruction/PC handoff.
interface if_pp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32
);
    logic                  imem_req;
    logic                  imem_ready;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic [INST_WIDTH-1:0] inst_out;
    logic [DATA_WIDTH-1:0] pc_out;
    logic                  insert_nop;
    logic                  flush;
    logic [DATA_WIDTH-1:0] jump_addr;

    modport master (
        output imem_req, imem_addr, inst_out, pc_out,
        input  imem_ready, imem_rvalid, imem_rdata, insert_nop, flush, jump_addr
    );

    modport slave (
        input  imem_req, imem_addr, inst_out, pc_out,
        output imem_ready, imem_rvalid, imem_rdata, insert_nop, flush, jump_addr
    );
endinterface

// File: rtl/if_pp.sv
// Instruction-fetch stage: in-order imem requests, small return FIFO, NOP bubbles to ID when empty.
// Optional IF_PERF_CNT_EN adds bubble_cnt / flush_cnt performance counters.
module if_pp #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] bubble_cnt,
    output logic [31:0] flush_cnt,
`endif
    if_pp_if.master     bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0033);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] ret_pc_q, ret_pc_d;
    logic [CNT_W-1:0]      in_flight_q, in_flight_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [INST_WIDTH-1:0] inst_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
    logic                  credit_ok, accept, resp, push, pop, empty;

    // Credit counts stale in-flight requests too, so a returning word always has a free slot.
    assign empty     = (occ_q == '0);
    assign credit_ok = (SUM_W'(in_flight_q) + SUM_W'(occ_q)) < SUM_W'(FIFO_DEPTH);
    assign bus.imem_req  = !rst && !bus.flush && credit_ok;
    assign bus.imem_addr = fetch_pc_q;
    assign accept = bus.imem_req && bus.imem_ready;
    // Responses with nothing tracked in flight belong to pre-reset requests and are ignored.
    assign resp   = bus.imem_rvalid && (in_flight_q != '0);
    assign push   = resp && (drop_cnt_q == '0) && !bus.flush;
    assign pop    = !empty && !bus.insert_nop && !bus.flush;

    assign bus.inst_out = empty ? NOP_INST : inst_mem_q[rd_ptr_q];
    assign bus.pc_out   = empty ? '0 : pc_mem_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        ret_pc_d    = ret_pc_q;
        drop_cnt_d  = drop_cnt_q;
        occ_d       = occ_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(resp);
        if (bus.flush) begin
            // Everything still outstanding after this cycle's response is now wrong-path.
            fetch_pc_d = bus.jump_addr & ~DATA_WIDTH'(3);
            ret_pc_d   = bus.jump_addr & ~DATA_WIDTH'(3);
            drop_cnt_d = in_flight_q - CNT_W'(resp);
            occ_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
            if (resp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
            if (push) begin
                ret_pc_d = ret_pc_q + DATA_WIDTH'(4);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            ret_pc_q    <= RESET_PC;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            ret_pc_q    <= ret_pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]   <= ret_pc_q;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (empty && !bus.insert_nop) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (bus.flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_pp.sv
// Bench for if_pp: randomized imem latency/ready/stall/flush against a queue-based fetch model.
module tb_if_pp;
    localparam int unsigned DEPTH   = 2;
    localparam logic [31:0] NOP     = 32'h0000_0033;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] WTAG    = 32'h5A00_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] due;
    } mem_t;

    logic clk;
    logic rst;
    logic rst_w;

    if_pp_if #(.DATA_WIDTH(32), .INST_WIDTH(32)) bus ();
    if_pp_if #(.DATA_WIDTH(32), .INST_WIDTH(32)) bus_w ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt, bubble_cnt_w, flush_cnt_w;
`endif

    if_pp #(.DATA_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef IF_PERF_CNT_EN
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt),
`endif
        .bus       (bus)
    );

    if_pp #(.DATA_WIDTH(32), .INST_WIDTH(32), .RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk       (clk),
        .rst       (rst_w),
`ifdef IF_PERF_CNT_EN
        .bubble_cnt(bubble_cnt_w),
        .flush_cnt (flush_cnt_w),
`endif
        .bus       (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned chk_cnt, pass_cnt;
    logic [31:0] cyc;
    int unsigned lat_lo, lat_hi;

    // Reference model: fetch PC, in-flight list {stale, addr}, delivered-word queue {pc, inst}.
    logic [31:0] m_fetch_pc;
    logic [32:0] m_infl [$];
    logic [63:0] m_fifo [$];
    logic [31:0] m_bubble, m_flush;
    mem_t        mem_q [$];

    logic        cur_r, cur_f, cur_n, cur_rdy, cur_rvalid;
    logic [31:0] cur_ja, cur_rdata;
    logic        exp_req;
    logic [31:0] exp_inst, exp_pc;
    logic [96:0] got_v, exp_v;

    task automatic drive(input logic r, input logic f, input logic n, input logic rdy,
                         input logic [31:0] ja);
        @(negedge clk);
        cur_r = r; cur_f = f; cur_n = n; cur_rdy = rdy; cur_ja = ja;
        cur_rvalid = 1'b0;
        if (mem_q.size() != 0) cur_rvalid = (mem_q[0].due <= cyc);
        cur_rdata = cur_rvalid ? mem_q[0].data : $urandom();
        rst = r;
        bus.flush = f; bus.insert_nop = n; bus.imem_ready = rdy; bus.jump_addr = ja;
        bus.imem_rvalid = cur_rvalid; bus.imem_rdata = cur_rdata;
        #1;
        exp_req = !r && !f && ((m_infl.size() + m_fifo.size()) < int'(DEPTH));
        if (m_fifo.size() == 0) begin
            exp_inst = NOP;
            exp_pc   = 32'h0;
        end else begin
            {exp_pc, exp_inst} = m_fifo[0];
        end
        exp_v = {exp_req, m_fetch_pc, exp_inst, exp_pc};
        got_v = {bus.imem_req, bus.imem_addr, bus.inst_out, bus.pc_out};
    endtask

    task automatic advance();
        logic [32:0] fl;
        logic        acc_dut;
        acc_dut = bus.imem_req && cur_rdy;
        if (cur_r) begin
            m_fetch_pc = 32'h0;
            m_infl.delete();
            m_fifo.delete();
            mem_q.delete();
            m_bubble = 32'h0;
            m_flush  = 32'h0;
        end else begin
            if (m_fifo.size() == 0 && !cur_n) m_bubble = m_bubble + 32'd1;
            if (cur_f) m_flush = m_flush + 32'd1;
            if (!cur_f && m_fifo.size() != 0 && !cur_n) void'(m_fifo.pop_front());
            if (cur_rvalid && m_infl.size() != 0) begin
                fl = m_infl.pop_front();
                if (!cur_f && !fl[32]) m_fifo.push_back({fl[31:0], cur_rdata});
            end
            if (cur_f) begin
                m_fifo.delete();
                for (int i = 0; i < m_infl.size(); i++) begin
                    fl = m_infl[i];
                    fl[32] = 1'b1;
                    m_infl[i] = fl;
                end
                m_fetch_pc = {cur_ja[31:2], 2'b00};
            end else if (exp_req && cur_rdy) begin
                m_infl.push_back({1'b0, m_fetch_pc});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (cur_rvalid) void'(mem_q.pop_front());
            if (acc_dut)
                mem_q.push_back({bus.imem_addr, $urandom(), cyc + 32'($urandom_range(lat_hi, lat_lo))});
        end
        @(posedge clk);
        cyc = cyc + 32'd1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        chk_cnt++;
        if (got_v !== {1'b0, 32'h0, NOP, 32'h0})
            $display("FAIL reset_state got=%h want=%h", got_v, {1'b0, 32'h0, NOP, 32'h0});
        else pass_cnt++;
        advance();
    endtask

    task automatic test_stream();
        logic [31:0] seq_pc;
        seq_pc = 32'h0;
        lat_lo = 1; lat_hi = 1;
        for (int k = 0; k < 24; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            chk_cnt++;
            if (got_v !== exp_v) $display("FAIL stream cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            else pass_cnt++;
            if (m_fifo.size() != 0) begin
                chk_cnt++;
                if (bus.pc_out !== seq_pc) $display("FAIL stream_pc got=%h want=%h", bus.pc_out, seq_pc);
                else pass_cnt++;
                seq_pc = seq_pc + 32'd4;
            end
            advance();
        end
        chk_cnt++;
        if (seq_pc < 32'h20) $display("FAIL stream_count words=%0d want>=8", seq_pc >> 2);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [31:0] hold_pc, hold_inst, next_pc;
        int k;
        for (k = 0; k < 10 && m_fifo.size() != DEPTH; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
            chk_cnt++;
            if (got_v !== exp_v) $display("FAIL stall_fill cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            else pass_cnt++;
            advance();
        end
        chk_cnt++;
        if (m_fifo.size() != DEPTH) $display("FAIL stall_fill_timeout occ=%0d want=%0d", m_fifo.size(), DEPTH);
        else pass_cnt++;
        {hold_pc, hold_inst} = m_fifo[0];
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
            chk_cnt++;
            if ({bus.imem_req, bus.inst_out, bus.pc_out} !== {1'b0, hold_inst, hold_pc})
                $display("FAIL stall_hold got=%h want=%h", {bus.imem_req, bus.inst_out, bus.pc_out},
                         {1'b0, hold_inst, hold_pc});
            else pass_cnt++;
            advance();
        end
        next_pc = hold_pc;
        for (int j = 0; j < 12; j++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            chk_cnt++;
            if (got_v !== exp_v) $display("FAIL stall_release cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            else pass_cnt++;
            if (m_fifo.size() != 0) begin
                chk_cnt++;
                if (bus.pc_out !== next_pc) $display("FAIL stall_contig got=%h want=%h", bus.pc_out, next_pc);
                else pass_cnt++;
                next_pc = next_pc + 32'd4;
            end
            advance();
        end
    endtask

    task automatic test_flush();
        logic found;
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 20 && m_infl.size() != 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            chk_cnt++;
            if (got_v !== exp_v) $display("FAIL flush_prep cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            else pass_cnt++;
            advance();
        end
        chk_cnt++;
        if (m_infl.size() != 2) $display("FAIL flush_prep_timeout inflight=%0d want=2", m_infl.size());
        else pass_cnt++;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h103);
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL flush_cycle got=%h want=%h", got_v, exp_v);
        else pass_cnt++;
        advance();
        found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            chk_cnt++;
            if (got_v !== exp_v) $display("FAIL flush_after cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            else pass_cnt++;
            if (k == 0) begin
                chk_cnt++;
                if (bus.imem_addr !== 32'h100) $display("FAIL flush_addr got=%h want=%h", bus.imem_addr, 32'h100);
                else pass_cnt++;
            end
            if (m_fifo.size() != 0) begin
                found = 1'b1;
                chk_cnt++;
                if (bus.pc_out !== 32'h100) $display("FAIL flush_first_pc got=%h want=%h", bus.pc_out, 32'h100);
                else pass_cnt++;
            end
            advance();
        end
        chk_cnt++;
        if (!found) $display("FAIL flush_timeout got=none want=pc 00000100");
        else pass_cnt++;
    endtask

    task automatic test_ready_low();
        lat_lo = 1; lat_hi = 3;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h200);
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL rdy_flush got=%h want=%h", got_v, exp_v);
        else pass_cnt++;
        advance();
        for (int k = 0; k < 10 && m_infl.size() != 0; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk_cnt++;
            if (got_v !== exp_v) $display("FAIL rdy_drain cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            else pass_cnt++;
            advance();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk_cnt++;
            if (got_v !== {1'b1, 32'h200, NOP, 32'h0})
                $display("FAIL rdy_low cyc=%0d got=%h want=%h", cyc, got_v, {1'b1, 32'h200, NOP, 32'h0});
            else pass_cnt++;
            advance();
        end
    endtask

    task automatic test_flush_rvalid_rst();
        logic hit, found;
        lat_lo = 2; lat_hi = 2;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (mem_q.size() != 0 && m_infl.size() != 0) hit = (mem_q[0].due <= cyc);
            if (!hit) begin
                drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
                chk_cnt++;
                if (got_v !== exp_v) $display("FAIL frr_prep cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
                else pass_cnt++;
                advance();
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
        chk_cnt++;
        if (got_v !== exp_v || !hit) $display("FAIL frr_flush rv=%b got=%h want=%h", cur_rvalid, got_v, exp_v);
        else pass_cnt++;
        advance();
        found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            if (m_fifo.size() != 0) begin
                found = 1'b1;
                chk_cnt++;
                if (bus.pc_out !== 32'h300) $display("FAIL frr_first_pc got=%h want=%h", bus.pc_out, 32'h300);
                else pass_cnt++;
            end
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
            advance();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL frr_rst_cycle got=%h want=%h", got_v, exp_v);
        else pass_cnt++;
        advance();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk_cnt++;
        if (got_v !== {1'b1, 32'h0, NOP, 32'h0})
            $display("FAIL frr_after_rst got=%h want=%h", got_v, {1'b1, 32'h0, NOP, 32'h0});
        else pass_cnt++;
        advance();
        found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            if (m_fifo.size() != 0) begin
                found = 1'b1;
                chk_cnt++;
                if (bus.pc_out !== 32'h0) $display("FAIL frr_restart_pc got=%h want=%h", bus.pc_out, 32'h0);
                else pass_cnt++;
            end
            advance();
        end
        chk_cnt++;
        if (!found) $display("FAIL frr_timeout got=none want=pc 00000000");
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic r, f, n, rdy;
        lat_lo = 1; lat_hi = 4;
        for (int k = 0; k < 300; k++) begin
            r   = ($urandom_range(99, 0) == 0);
            f   = ($urandom_range(19, 0) == 0);
            n   = ($urandom_range(4, 0) == 0);
            rdy = ($urandom_range(3, 0) != 0);
            drive(r, f, n, rdy, $urandom());
            chk_cnt++;
            if (got_v !== exp_v) $display("FAIL random cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            else pass_cnt++;
            advance();
        end
    endtask

    task automatic test_perf();
`ifdef IF_PERF_CNT_EN
        @(negedge clk);
        chk_cnt++;
        if ({bubble_cnt, flush_cnt} !== {m_bubble, m_flush})
            $display("FAIL perf_cnt got=%h want=%h", {bubble_cnt, flush_cnt}, {m_bubble, m_flush});
        else pass_cnt++;
`endif
    endtask

    task automatic test_wrap();
        logic        pend;
        logic [31:0] pend_addr;
        logic [31:0] wrap_seq [3];
        int          idx;
        wrap_seq[0] = 32'hFFFF_FFF8;
        wrap_seq[1] = 32'hFFFF_FFFC;
        wrap_seq[2] = 32'h0000_0000;
        pend = 1'b0; pend_addr = 32'h0; idx = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            rst = 1'b1;
            rst_w = 1'b0;
            bus_w.imem_rvalid = pend;
            bus_w.imem_rdata  = pend_addr ^ WTAG;
            #1;
            if (k == 0) begin
                chk_cnt++;
                if ({bus_w.imem_req, bus_w.imem_addr, bus_w.inst_out, bus_w.pc_out} !== {1'b1, WRAP_PC, NOP, 32'h0})
                    $display("FAIL wrap_reset got=%h want=%h",
                             {bus_w.imem_req, bus_w.imem_addr, bus_w.inst_out, bus_w.pc_out},
                             {1'b1, WRAP_PC, NOP, 32'h0});
                else pass_cnt++;
            end
            if (bus_w.inst_out !== NOP && idx < 3) begin
                chk_cnt++;
                if ({bus_w.inst_out, bus_w.pc_out} !== {wrap_seq[idx] ^ WTAG, wrap_seq[idx]})
                    $display("FAIL wrap_pc idx=%0d got=%h want=%h", idx, {bus_w.inst_out, bus_w.pc_out},
                             {wrap_seq[idx] ^ WTAG, wrap_seq[idx]});
                else pass_cnt++;
                idx++;
            end
            pend      = bus_w.imem_req && bus_w.imem_ready;
            pend_addr = bus_w.imem_addr;
            @(posedge clk);
        end
        chk_cnt++;
        if (idx != 3) $display("FAIL wrap_count got=%0d want=3", idx);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.insert_nop = 1'b0; bus.flush = 1'b0; bus.jump_addr = 32'h0;
        bus_w.imem_ready = 1'b1; bus_w.imem_rvalid = 1'b0; bus_w.imem_rdata = 32'h0;
        bus_w.insert_nop = 1'b0; bus_w.flush = 1'b0; bus_w.jump_addr = 32'h0;
        chk_cnt = 0; pass_cnt = 0; cyc = 32'h0; lat_lo = 1; lat_hi = 1;
        m_fetch_pc = 32'h0; m_bubble = 32'h0; m_flush = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_ready_low();
        test_flush_rvalid_rst();
        test_random();
        test_perf();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
